// File: rtl/per_resp_tracker.sv
// per_resp_tracker: response-path companion to the peripheral address decoder.
// Remembers, in request order, which peripheral port each accepted request
// went to. It forwards the matching response from that port back to the
// initiator and flags responses arriving from any other port.
//
// Handshake: a push happens only in a cycle where req_fire_i && req_ready_o.
// req_ready_o is combinational from the count and rst_ni, so the initiator
// grant can be gated with it. The response side has no back-pressure:
// r_valid_o and err_unexp_o are single-cycle pulses, one cycle after the
// per-port response that caused them.
module per_resp_tracker #(
    parameter int DATA_WIDTH      = 32,
    parameter int PE_XBAR_N_OUPS  = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int IDX_W           = $clog2(PE_XBAR_N_OUPS),
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 req_fire_i,
    input  logic [IDX_W-1:0]                     req_idx_i,
    output logic                                 req_ready_o,
    input  logic [PE_XBAR_N_OUPS-1:0]            pe_r_valid_i,
    input  logic [PE_XBAR_N_OUPS*DATA_WIDTH-1:0] pe_r_rdata_i,
    input  logic [PE_XBAR_N_OUPS-1:0]            pe_r_opc_i,
    output logic                                 r_valid_o,
    output logic [DATA_WIDTH-1:0]                r_rdata_o,
    output logic                                 r_opc_o,
    output logic [CNT_W-1:0]                     outstanding_o,
    output logic                                 err_unexp_o
);

    localparam int               PTR_W   = $clog2(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    // Order queue storage and bookkeeping
    logic [IDX_W-1:0]      r_queue [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_cnt;

    // Registered response outputs
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_opc;
    logic                  r_err;

    logic [IDX_W-1:0]          w_head;
    logic                      w_nonempty;
    logic                      w_ready;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_unexp;
    logic [PE_XBAR_N_OUPS-1:0] w_head_mask;
    logic [PE_XBAR_N_OUPS-1:0] w_expect_mask;
    logic [DATA_WIDTH-1:0]     w_head_rdata;
    logic                      w_head_opc;

    assign w_head     = r_queue[r_rptr];
    assign w_nonempty = (r_cnt != '0);
    // No bypass from pop to ready: a full queue stays not-ready this cycle.
    assign w_ready    = rst_ni && (r_cnt < CNT_MAX);
    assign w_push     = req_fire_i && w_ready;

    // Decode the head index into a port mask and select that port's response
    always_comb begin
        w_head_mask  = '0;
        w_head_rdata = '0;
        w_head_opc   = 1'b0;
        for (int p = 0; p < PE_XBAR_N_OUPS; p++) begin
            if (IDX_W'(p) == w_head) begin
                w_head_mask[p] = 1'b1;
                w_head_rdata   = pe_r_rdata_i[p*DATA_WIDTH +: DATA_WIDTH];
                w_head_opc     = pe_r_opc_i[p];
            end
        end
    end

    // Only the head port may answer; with an empty queue no port may.
    assign w_expect_mask = w_nonempty ? w_head_mask : '0;
    assign w_pop         = |(pe_r_valid_i & w_expect_mask);
    assign w_unexp       = |(pe_r_valid_i & ~w_expect_mask);

    // Queue entry write; contents need no reset because count gates every read
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_queue[r_wptr] <= req_idx_i;
        end
    end

    // Pointers and count; a simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Response register: one-cycle latency, data and opcode hold between responses
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_rdata <= '0;
            r_opc   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= w_pop;
            r_err   <= w_unexp;
            if (w_pop) begin
                r_rdata <= w_head_rdata;
                r_opc   <= w_head_opc;
            end
        end
    end

    assign req_ready_o   = w_ready;
    assign r_valid_o     = r_valid;
    assign r_rdata_o     = r_rdata;
    assign r_opc_o       = r_opc;
    assign err_unexp_o   = r_err;
    assign outstanding_o = r_cnt;

endmodule

// File: doc/per_resp_tracker.md
# per_resp_tracker

Response-path companion to the cluster peripheral-interconnect address decoder. It records, in request order, the peripheral port index each accepted request was routed to. It then steers the matching response from the per-port response buses back to the single initiator port. Responses arriving from any port other than the one at the head of the order queue are flagged and dropped. One instance sits on each initiator-side port of the peripheral crossbar.

## Interface
- DATA_WIDTH, 32, response data width.
- PE_XBAR_N_OUPS, 8, number of peripheral ports; IDX_W = $clog2(PE_XBAR_N_OUPS).
- MAX_OUTSTANDING, 4, depth of the order queue; must be a power of two ≥ 2; CNT_W = $clog2(MAX_OUTSTANDING+1).
- clk_i  in  1  cluster clock; all state on the rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- req_fire_i  in  1  a request is accepted on the initiator side this cycle (req & gnt).
- req_idx_i  in  IDX_W  decoded peripheral index of that request.
- req_ready_o  out  1  queue can take a push this cycle; the initiator grant is gated with it.
- pe_r_valid_i  in  PE_XBAR_N_OUPS  per-port response valid.
- pe_r_rdata_i  in  PE_XBAR_N_OUPS*DATA_WIDTH  per-port response data; port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
- pe_r_opc_i  in  PE_XBAR_N_OUPS  per-port error/opcode bit.
- r_valid_o  out  1  response valid to the initiator.
- r_rdata_o  out  DATA_WIDTH  response data.
- r_opc_o  out  1  response error bit.
- outstanding_o  out  CNT_W  number of queued, unanswered requests.
- err_unexp_o  out  1  one-cycle pulse: an unexpected response was seen.

## Operation
- Storage: circular queue of IDX_W-bit entries, with write pointer, read pointer and count registers. Pointers wrap modulo MAX_OUTSTANDING.
- Push: req_fire_i && req_ready_o writes req_idx_i at the write pointer, then increments the pointer and the count.
- req_fire_i while req_ready_o=0 is ignored: no push and no error. The bench asserts that this never happens.
- Head match: the count is nonzero and pe_r_valid_i[head] is 1, where head is the entry at the read pointer.
- On a head match:
  - register r_valid_o=1, r_rdata_o=pe_r_rdata_i[head], r_opc_o=pe_r_opc_i[head];
  - pop, incrementing the read pointer and decrementing the count.
- Unexpected response: any set bit of pe_r_valid_i other than the head bit, or any set bit while the count is 0.
  - Such a response is dropped and never forwarded.
  - err_unexp_o=1 in the following cycle.
  - A head match in the same cycle is still forwarded normally.
- Simultaneous push and pop: the count is unchanged and both pointers advance.
- Pop is not decided by a same-cycle push. A request accepted in cycle t can only be matched from cycle t+1, because the response to it cannot arrive in the same cycle.
- Full queue: req_ready_o=0 even if a pop occurs in the same cycle. There is no bypass from pop to ready.
- outstanding_o equals the count register.
- Reset mid-operation:
  - all queue contents are discarded; pointers and count go to 0;
  - responses arriving after reset to pre-reset requests are flagged as unexpected.

## Timing
- Reset values:
  - r_valid_o=0, r_rdata_o=0, r_opc_o=0, err_unexp_o=0, outstanding_o=0.
  - req_ready_o=0 while rst_ni=0, and 1 in the first cycle after release.
- req_ready_o is combinational from the count: it is 1 when count < MAX_OUTSTANDING and rst_ni=1.
- Response latency: exactly 1 cycle from pe_r_valid_i to r_valid_o.
- r_valid_o and err_unexp_o are single-cycle per event; there is no back-pressure on the response side.
- When r_valid_o=0, r_rdata_o and r_opc_o hold their last value.
- Throughput: one push and one pop per cycle are sustained.

## Test plan
- Reset, then push idx 3 at t0, then pe_r_valid_i[3]=1 with rdata 0xCAFE0003 at t2 -> r_valid_o=1, r_rdata_o=0xCAFE0003 at t3; outstanding_o goes 1 then 0; err_unexp_o stays 0.
- Push idx 1, 5, 1, 7 (MAX_OUTSTANDING=4) -> req_ready_o=0 after the 4th push. Then responses from ports 1, 5, 1, 7 in successive cycles -> four r_valid_o pulses in order; req_ready_o returns to 1 after the first pop plus one cycle.
- Queue holds [2, 4]; response from port 4 first -> dropped, err_unexp_o pulses once, outstanding_o stays 2. A later response from port 2 -> forwarded.
- Empty queue, pe_r_valid_i=8'h01 -> err_unexp_o=1 next cycle, r_valid_o=0.
- Full queue, with a head match and req_fire_i in the same cycle -> pop happens, push is ignored, outstanding_o=3. Streaming push and pop at one per cycle for 100 cycles -> no errors, and outstanding_o stays constant.
- Two requests outstanding, rst_ni low for one cycle -> all outputs 0 and outstanding_o=0. Afterwards a response from the old head port -> err_unexp_o pulses and nothing is forwarded.
